// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: round-robin arbiter sharing one FP adder between two requesters,
// with a WAIT timeout that returns an error response instead of hanging.
module fpadd_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_op1_0,
    input  logic [31:0] req_op2_0,
    input  logic [31:0] req_op1_1,
    input  logic [31:0] req_op2_1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic [31:0] fpa_op1,
    output logic [31:0] fpa_op2,
    output logic        fpa_start,
    input  logic        fpa_done,
    input  logic [31:0] fpa_result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state, state_nx;
    logic [31:0] op1_q, op2_q, res_q;
    logic        err_q, win_q, ptr_q;
    logic [7:0]  timer_q;
    logic [1:0]  grant;
    logic        timeout;
    // Contention goes to the pointer; a lone request simply wins.
    assign grant   = (req_valid == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req_valid;
    assign timeout = timer_q == 8'(TIMEOUT_CYC - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req_valid ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (fpa_done || timeout) ? RESP : WAIT;
            RESP:    state_nx = rsp_ready[win_q] ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready  = (state == IDLE) ? grant : 2'b00;
        fpa_start  = state == ISSUE;
        fpa_op1    = (state == ISSUE || state == WAIT) ? op1_q : 32'd0;
        fpa_op2    = (state == ISSUE || state == WAIT) ? op2_q : 32'd0;
        rsp_valid  = (state == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
        rsp_result = (state == RESP) ? res_q : 32'd0;
        rsp_err    = (state == RESP) && err_q;
        busy       = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            win_q   <= 1'b0;
            ptr_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |req_valid) begin
                win_q <= grant[1];
                op1_q <= grant[1] ? req_op1_1 : req_op1_0;
                op2_q <= grant[1] ? req_op2_1 : req_op2_0;
            end
            if (state == ISSUE)
                timer_q <= '0;
            // Done wins over a coincident timeout.
            if (state == WAIT) begin
                timer_q <= timer_q + 8'd1;
                if (fpa_done) begin
                    res_q <= fpa_result;
                    err_q <= 1'b0;
                end else if (timeout) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end
            end
            if (state == RESP && rsp_ready[win_q])
                ptr_q <= ~win_q;
        end
    end
endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb_fpadd_arbiter: directed checks of fpadd_arbiter, with the bench acting as the adder.
module tb_fpadd_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_op1_0 = 32'h3F80_0000;
    logic [31:0] req_op2_0 = 32'h4000_0000;
    logic [31:0] req_op1_1 = 32'h4040_0000;
    logic [31:0] req_op2_1 = 32'h4080_0000;
    logic [1:0]  req_ready, rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_result, fpa_op1, fpa_op2;
    logic        rsp_err, fpa_start, busy;
    logic        fpa_done = 1'b0;
    logic [31:0] fpa_result = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    fpadd_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_op1_0(req_op1_0), .req_op2_0(req_op2_0),
        .req_op1_1(req_op1_1), .req_op2_1(req_op2_1),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .fpa_op1(fpa_op1), .fpa_op2(fpa_op2), .fpa_start(fpa_start),
        .fpa_done(fpa_done), .fpa_result(fpa_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rvalid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_result"}, rsp_result, 32'd0);
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_start"}, 32'(fpa_start), 32'd0);
        check({tag, "_op1"}, fpa_op1, 32'd0);
        check({tag, "_op2"}, fpa_op2, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("rst");
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet("rst_rel");
    endtask

    // Runs one job from IDLE (caller at a negedge). dly<0 means the adder never answers.
    task automatic job(input string tag, input logic [1:0] valid, input logic [1:0] win,
                       input int dly, input logic [31:0] res, input logic [31:0] exp_res,
                       input logic exp_err, input int hold);
        int n;
        logic [31:0] e1, e2;
        e1 = win[1] ? req_op1_1 : req_op1_0;
        e2 = win[1] ? req_op2_1 : req_op2_0;
        req_valid = valid;
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(win));
        @(negedge clk);
        check({tag, "_start"}, 32'(fpa_start), 32'd1);
        check({tag, "_op1"}, fpa_op1, e1);
        check({tag, "_noready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_start_pulse"}, 32'(fpa_start), 32'd0);
        check({tag, "_op2"}, fpa_op2, e2);
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            if (n == dly) begin
                fpa_done = 1'b1;
                fpa_result = res;
            end
            @(negedge clk);
            fpa_done = 1'b0;
            n++;
        end
        check({tag, "_wait_cycles"}, 32'(n), dly >= 0 ? 32'(dly + 1) : 32'd16);
        check({tag, "_rvalid"}, 32'(rsp_valid), 32'(win));
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 2'b11;
            rsp_ready = ~win;
            @(negedge clk);
            check({tag, "_hold_rvalid"}, 32'(rsp_valid), 32'(win));
            check({tag, "_hold_result"}, rsp_result, exp_res);
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, "_hold_busy"}, 32'(busy), 32'd1);
        end
        req_valid = valid;
        rsp_ready = win;
        @(negedge clk);
        rsp_ready = 2'b00;
        check({tag, "_done_rvalid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        req_valid = 2'b00;
    endtask

    initial begin
        #1;
        check_quiet("por");
        do_reset();
        job("basic", 2'b01, 2'b01, 2, 32'h4040_0000, 32'h4040_0000, 1'b0, 0);
        do_reset();
        job("rr0", 2'b11, 2'b01, 1, 32'h4040_0000, 32'h4040_0000, 1'b0, 0);
        job("rr1", 2'b11, 2'b10, 0, 32'h40E0_0000, 32'h40E0_0000, 1'b0, 0);
        job("rr2", 2'b11, 2'b01, 4, 32'h4040_0000, 32'h4040_0000, 1'b0, 0);
        job("tmo", 2'b01, 2'b01, -1, 32'h0, 32'h0, 1'b1, 0);
        job("tie", 2'b10, 2'b10, 15, 32'h40E0_0000, 32'h40E0_0000, 1'b0, 0);
        job("stall", 2'b10, 2'b10, 3, 32'h40E0_0000, 32'h40E0_0000, 1'b0, 5);
        // Reset during WAIT, then a late done
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fpa_done = 1'b1;
        fpa_result = 32'h1234_5678;
        @(negedge clk);
        fpa_done = 1'b0;
        check_quiet("late_done");
        @(negedge clk);
        check_quiet("late_done2");
        // Spurious done while IDLE must not leak into the next result
        fpa_done = 1'b1;
        fpa_result = 32'hDEAD_BEEF;
        @(negedge clk);
        fpa_done = 1'b0;
        check_quiet("spur");
        job("after_spur", 2'b10, 2'b10, 0, 32'h40E0_0000, 32'h40E0_0000, 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fpadd_arbiter.md
FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning max WAIT cycles before a job is aborted (legal range 2..255).
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  2  per-requester job request, bit i for requester i.
REQ-005 SHALL have req_op1_0, req_op2_0, req_op1_1, req_op2_1  input  32 each  IEEE-754 single operands per requester.
REQ-006 SHALL have req_ready  output  2  one-hot accept; a job transfers when req_valid[i] and req_ready[i] are both high.
REQ-007 SHALL have rsp_valid  output  2  one-hot result-available to the owning requester.
REQ-008 SHALL have rsp_ready  input  2  per-requester result acceptance.
REQ-009 SHALL have rsp_result  output  32  sum returned to the requester; rsp_err  output  1  timeout flag.
REQ-010 SHALL have fpa_op1, fpa_op2  output  32 each  operands driven to the shared adder.
REQ-011 SHALL have fpa_start  output  1  one-cycle start pulse; fpa_done  input  1  adder completion; fpa_result  input  32  adder sum.
REQ-012 SHALL have busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one state per cycle except WAIT and RESP, which may hold.
REQ-014 IDLE: req_ready SHALL be combinationally one-hot for the winner when any req_valid is high, else 2'b00.
REQ-015 Arbitration SHALL be round-robin: single valid wins; both valid -> requester indicated by priority pointer wins.
REQ-016 On transfer, the block SHALL capture both operands and the winner id into internal registers and go to ISSUE.
REQ-017 ISSUE: fpa_start SHALL be high for exactly one cycle; fpa_op1/fpa_op2 SHALL equal captured operands from ISSUE until leaving WAIT.
REQ-018 WAIT: a 8-bit timer SHALL clear on entry and increment each cycle; fpa_done high -> capture fpa_result, rsp_err=0, go to RESP.
REQ-019 WAIT: if timer reaches TIMEOUT_CYC-1 without fpa_done -> rsp_result=0, rsp_err=1, go to RESP.
REQ-020 fpa_done and timeout on same cycle SHALL be treated as done (no error).
REQ-021 fpa_done outside WAIT SHALL be ignored and SHALL not alter any register.
REQ-022 RESP: rsp_valid[winner] SHALL stay high with stable rsp_result/rsp_err until rsp_ready[winner]; then IDLE.
REQ-023 On RESP exit, priority pointer SHALL be set to the non-winning requester.
REQ-024 rsp_ready of the non-owning requester SHALL have no effect.
REQ-025 Latency: transfer-to-fpa_start 1 cycle; fpa_done-to-rsp_valid 1 cycle; minimum transfer-to-rsp_valid 3 cycles.
REQ-026 No new job SHALL be accepted (req_ready=0) outside IDLE.
REQ-027 fpa_op1/fpa_op2 SHALL be 0 in IDLE.

Reset
REQ-028 reset low SHALL immediately force IDLE, pointer=0, timer=0, captured registers=0.
REQ-029 During and after reset, req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, fpa_start=0, fpa_op1=fpa_op2=0, busy=0.
REQ-030 Reset mid-job SHALL discard the job with no response; a late fpa_done after reset release SHALL be ignored.

Verification
REQ-031 req_valid=01, ops 0x3F800000/0x40000000, fpa_done 3 cycles after start with 0x40400000 -> req_ready=01, fpa_start pulse, rsp_valid=01, rsp_result=0x40400000, rsp_err=0.
REQ-032 req_valid=11 held for 3 jobs from reset -> grants 0,1,0 in order; pointer toggles after each RESP.
REQ-033 fpa_done never asserted, TIMEOUT_CYC=16 -> rsp_valid after 16 WAIT cycles, rsp_result=0, rsp_err=1.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=00 on other requester, busy=1.
REQ-035 reset asserted in WAIT, fpa_done 2 cycles after release -> no rsp_valid, state IDLE, all outputs 0.
REQ-036 fpa_done pulse while IDLE, then new job -> result of new job only; spurious done not reported.
